// File: rtl/avalon_data_master_pkg.sv
// Shared types and helpers for the Avalon data master: size and state encodings,
// alignment checks, and store lane steering.
package avalon_data_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUS   = 2'b01,
    ST_RDATA = 2'b10
  } state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the store data means the slave finds it on whichever lane is enabled.
  function automatic logic [31:0] replicate_wdata(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/avalon_data_master_load_align.sv
// Load lane extraction: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it to 32 bits.
module load_align
  import avalon_data_master_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (size_e'(size))
      SZ_BYTE: result = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{is_signed & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/avalon_data_master.sv
// Single-outstanding Avalon-MM data master: turns CPU byte/half/word loads and
// stores into one bus transfer each, with alignment checking and stall timeout.
module avalon_data_master
  import avalon_data_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES    = 256,
  parameter logic [31:0] RESET_VECTOR_BASE = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  state_e      state_q, state_d;
  logic        accept, misalign, ack, timeout, rd_capture;
  logic [1:0]  lane_q, size_q;
  logic        signed_q;
  logic [31:0] stall_cnt;
  logic [31:0] load_result;

  load_align u_load_align (
    .lane      (lane_q),
    .size      (size_q),
    .is_signed (signed_q),
    .word      (readdata),
    .result    (load_result)
  );

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    misalign   = 1'b0;
    ack        = 1'b0;
    timeout    = 1'b0;
    rd_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (is_misaligned(size_e'(cpu_size), cpu_addr[1:0])) begin
            misalign = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          ack     = 1'b1;
          state_d = write ? ST_IDLE : ST_RDATA;
        end else if ((TIMEOUT_CYCLES != 0) && (stall_cnt == TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RDATA: begin
        rd_capture = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      byteenable <= '0;
      writedata  <= '0;
      address    <= RESET_VECTOR_BASE;
      stall_cnt  <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_busy <= (state_d != ST_IDLE);
      cpu_done <= (ack && write) || rd_capture;
      cpu_err  <= misalign || timeout;

      if (state_q == ST_IDLE && cpu_req) begin
        lane_q   <= cpu_addr[1:0];
        size_q   <= cpu_size;
        signed_q <= cpu_signed;
      end

      // Strobes and bus fields are loaded once on accept and simply held through stalls.
      if (accept) begin
        read       <= !cpu_we;
        write      <= cpu_we;
        address    <= {cpu_addr[31:2], 2'b00};
        byteenable <= lane_enables(size_e'(cpu_size), cpu_addr[1:0]);
        writedata  <= cpu_we ? replicate_wdata(size_e'(cpu_size), cpu_wdata) : 32'd0;
        stall_cnt  <= '0;
      end else if (ack || timeout) begin
        read       <= 1'b0;
        write      <= 1'b0;
        byteenable <= '0;
        writedata  <= '0;
        address    <= RESET_VECTOR_BASE;
      end else if (state_q == ST_BUS && waitrequest) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      if (rd_capture) begin
        cpu_rdata <= load_result;
      end
    end
  end

endmodule

// File: tb/tb_avalon_data_master.sv
// Self-checking bench for avalon_data_master: directed scenarios plus randomized
// transactions scored against a transaction-level model.
module tb_avalon_data_master;

  localparam int unsigned TO = 4;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_signed = 1'b0, waitrequest = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, readdata = '0;
  logic        cpu_busy, cpu_done, cpu_err, read, write;
  logic [31:0] cpu_rdata, address, writedata;
  logic [3:0]  byteenable;

  int          total = 0;
  int          passed = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  avalon_data_master #(.TIMEOUT_CYCLES(TO), .RESET_VECTOR_BASE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_signed(cpu_signed), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .address(address),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  // Reference model: plain arithmetic on the address and data.
  function automatic logic mis_model(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [31:0] a);
    int k;
    k = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << k);
    if (sz == 2'd1) return 4'(3 << k);
    return 4'd15;
  endfunction

  function automatic logic [31:0] wd_model(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'd255) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'd65535) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] rd_model(input logic [1:0] sz, input logic [31:0] a,
                                           input logic sgn, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v & 32'd255;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = v & 32'd65535;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic run_txn(input string nm, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic sgn,
                         input logic [31:0] rd, input int stalls);
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    logic        tmo;
    int          ncyc;
    ebe   = be_model(sz, a);
    ewd   = we ? wd_model(sz, wd) : 32'd0;
    eaddr = a - (a % 4);
    tmo   = (stalls >= int'(TO));
    ncyc  = tmo ? int'(TO) : stalls + 1;
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd; cpu_signed = sgn;
    waitrequest = (stalls > 0); readdata = $urandom;
    @(posedge clk); #1;
    if (mis_model(sz, a)) begin
      cpu_req = 1'b0;
      total++;
      if (cpu_err !== 1'b1 || cpu_done !== 1'b0)
        $display("FAIL %s misalign pulse: err=%b done=%b want err=1 done=0", nm, cpu_err, cpu_done);
      else passed++;
      total++;
      if (read !== 1'b0 || write !== 1'b0 || cpu_busy !== 1'b0)
        $display("FAIL %s misalign idle: read=%b write=%b busy=%b want 0 0 0", nm, read, write, cpu_busy);
      else passed++;
      total++;
      if (cpu_rdata !== model_rdata)
        $display("FAIL %s misalign rdata: got %h want %h", nm, cpu_rdata, model_rdata);
      else passed++;
      return;
    end
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      waitrequest = (i < stalls);
      cpu_req = 1'($urandom); cpu_addr = $urandom; cpu_we = 1'($urandom); cpu_size = 2'($urandom);
      total++;
      if (read !== !we || write !== we || address !== eaddr || byteenable !== ebe ||
          writedata !== ewd || cpu_done !== 1'b0 || cpu_err !== 1'b0 || cpu_busy !== 1'b1)
        $display("FAIL %s bus cyc%0d: rd=%b wr=%b addr=%h be=%b wd=%h done=%b err=%b busy=%b want rd=%b wr=%b addr=%h be=%b wd=%h done=0 err=0 busy=1",
                 nm, i, read, write, address, byteenable, writedata, cpu_done, cpu_err, cpu_busy,
                 !we, we, eaddr, ebe, ewd);
      else passed++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; waitrequest = 1'b0;
    if (tmo) begin
      total++;
      if (cpu_err !== 1'b1 || cpu_done !== 1'b0 || read !== 1'b0 || write !== 1'b0 || cpu_busy !== 1'b0)
        $display("FAIL %s timeout: err=%b done=%b rd=%b wr=%b busy=%b want 1 0 0 0 0",
                 nm, cpu_err, cpu_done, read, write, cpu_busy);
      else passed++;
      total++;
      if (cpu_rdata !== model_rdata)
        $display("FAIL %s timeout rdata: got %h want %h", nm, cpu_rdata, model_rdata);
      else passed++;
    end else if (we) begin
      total++;
      if (cpu_done !== 1'b1 || cpu_err !== 1'b0)
        $display("FAIL %s store done: done=%b err=%b want 1 0", nm, cpu_done, cpu_err);
      else passed++;
      total++;
      if (read !== 1'b0 || write !== 1'b0 || byteenable !== 4'd0 || writedata !== 32'd0 ||
          address !== RV || cpu_busy !== 1'b0)
        $display("FAIL %s store idle: rd=%b wr=%b be=%b wd=%h addr=%h busy=%b want 0 0 0000 0 %h 0",
                 nm, read, write, byteenable, writedata, address, cpu_busy, RV);
      else passed++;
    end else begin
      readdata = rd; cpu_req = 1'($urandom);
      total++;
      if (read !== 1'b0 || cpu_done !== 1'b0 || cpu_err !== 1'b0 || cpu_busy !== 1'b1)
        $display("FAIL %s rdata phase: rd=%b done=%b err=%b busy=%b want 0 0 0 1",
                 nm, read, cpu_done, cpu_err, cpu_busy);
      else passed++;
      @(posedge clk); #1;
      cpu_req = 1'b0; readdata = $urandom;
      model_rdata = rd_model(sz, a, sgn, rd);
      total++;
      if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== model_rdata)
        $display("FAIL %s load result: done=%b err=%b rdata=%h want done=1 err=0 rdata=%h",
                 nm, cpu_done, cpu_err, cpu_rdata, model_rdata);
      else passed++;
      total++;
      if (cpu_busy !== 1'b0 || address !== RV)
        $display("FAIL %s load idle: busy=%b addr=%h want 0 %h", nm, cpu_busy, address, RV);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cpu_busy !== 1'b0 || cpu_done !== 1'b0 || cpu_err !== 1'b0 || read !== 1'b0 ||
        write !== 1'b0 || byteenable !== 4'd0 || writedata !== 32'd0 || address !== RV ||
        cpu_rdata !== 32'd0)
      $display("FAIL reset: busy=%b done=%b err=%b rd=%b wr=%b be=%b wd=%h addr=%h rdata=%h want all 0, addr=%h",
               cpu_busy, cpu_done, cpu_err, read, write, byteenable, writedata, address, cpu_rdata, RV);
    else passed++;
    model_rdata = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_word_load();
    run_txn("word_load", 1'b0, 2'd2, 32'hBFC00004, 32'd0, 1'b0, 32'h11223344, 0);
  endtask

  task automatic test_byte_load();
    run_txn("byte_load_s", 1'b0, 2'd0, 32'hBFC00003, 32'd0, 1'b1, 32'h80000000, 0);
    run_txn("byte_load_u", 1'b0, 2'd0, 32'hBFC00003, 32'd0, 1'b0, 32'h80000000, 0);
    run_txn("half_load_s", 1'b0, 2'd1, 32'hBFC00002, 32'd0, 1'b1, 32'h9ABC1234, 1);
  endtask

  task automatic test_half_store();
    run_txn("half_store", 1'b1, 2'd1, 32'hBFC00002, 32'h0000ABCD, 1'b0, 32'd0, 3);
    run_txn("byte_store", 1'b1, 2'd0, 32'hBFC00001, 32'h123456E7, 1'b0, 32'd0, 0);
  endtask

  task automatic test_misaligned();
    run_txn("mis_word", 1'b0, 2'd2, 32'hBFC00001, 32'd0, 1'b0, 32'd0, 0);
    run_txn("mis_half", 1'b1, 2'd1, 32'hBFC00003, 32'h5555, 1'b0, 32'd0, 0);
    run_txn("mis_size3", 1'b0, 2'd3, 32'hBFC00000, 32'd0, 1'b0, 32'd0, 0);
  endtask

  task automatic test_timeout();
    run_txn("timeout_rd", 1'b0, 2'd2, 32'hBFC00010, 32'd0, 1'b0, 32'hDEADBEEF, 8);
    run_txn("timeout_wr", 1'b1, 2'd2, 32'hBFC00020, 32'hCAFEF00D, 1'b0, 32'd0, 4);
  endtask

  task automatic test_reset_mid_bus();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'hBFC00008; cpu_signed = 1'b0;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    total++;
    if (read !== 1'b1) $display("FAIL rst_mid read_up: got %b want 1", read);
    else passed++;
    reset_n = 1'b0; readdata = 32'h76543210;
    @(posedge clk); #1;
    total++;
    if (read !== 1'b0 || cpu_done !== 1'b0 || cpu_err !== 1'b0 || cpu_busy !== 1'b0 || cpu_rdata !== 32'd0)
      $display("FAIL rst_mid abort: rd=%b done=%b err=%b busy=%b rdata=%h want 0 0 0 0 0",
               read, cpu_done, cpu_err, cpu_busy, cpu_rdata);
    else passed++;
    reset_n = 1'b1; waitrequest = 1'b0; model_rdata = '0;
    @(posedge clk); #1;
    total++;
    if (cpu_done !== 1'b0 || cpu_err !== 1'b0)
      $display("FAIL rst_mid no_pulse: done=%b err=%b want 0 0", cpu_done, cpu_err);
    else passed++;
    run_txn("after_rst", 1'b0, 2'd2, 32'hBFC00008, 32'd0, 1'b0, 32'h0BADF00D, 1);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_0", 1'b1, 2'd2, 32'h00001000, 32'h01020304, 1'b0, 32'd0, 0);
    run_txn("b2b_1", 1'b0, 2'd1, 32'h00001002, 32'd0, 1'b0, 32'hFEDC8765, 0);
    run_txn("b2b_2", 1'b1, 2'd0, 32'h00001003, 32'h000000A5, 1'b0, 32'd0, 0);
    run_txn("b2b_3", 1'b0, 2'd0, 32'h00001001, 32'd0, 1'b1, 32'h0000F200, 0);
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      sz = ($urandom_range(15, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      a  = $urandom;
      if ($urandom_range(3, 0) != 0) begin
        if (sz == 2'd1) a = a - (a % 2);
        if (sz == 2'd2) a = a - (a % 4);
      end
      run_txn("random", 1'($urandom), sz, a, $urandom, 1'($urandom), $urandom,
              int'($urandom_range(5, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/avalon_data_master.md
AVALON_DATA_MASTER -- requirements
Module: avalon_data_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, max consecutive cycles waitrequest may stall one transfer before abort; 0 disables timeout.
REQ-002 Parameter RESET_VECTOR_BASE, default 32'hBFC00000, value placed on address while idle.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 cpu_req  input  1  request strobe; sampled only when cpu_busy=0.
REQ-006 cpu_we  input  1  1=store, 0=load.
REQ-007 cpu_size  input  2  00=byte, 01=half, 10=word; 11 treated as misaligned (error).
REQ-008 cpu_signed  input  1  sign-extend byte/half loads when 1, zero-extend when 0.
REQ-009 cpu_addr  input  32  byte address.
REQ-010 cpu_wdata  input  32  store data, right-justified.
REQ-011 cpu_busy  output  1  high in every state except IDLE.
REQ-012 cpu_done  output  1  one-cycle completion pulse.
REQ-013 cpu_err  output  1  one-cycle error pulse (misaligned or timeout); mutually exclusive with cpu_done.
REQ-014 cpu_rdata  output  32  extended load result; held until next cpu_done.
REQ-015 address  output  32  word-aligned Avalon address (bits [1:0]=00).
REQ-016 read / write  output  1 each  Avalon strobes; never both high.
REQ-017 byteenable  output  4  bit i enables data bits [8i+7:8i].
REQ-018 writedata  output  32  lane-replicated store data.
REQ-019 waitrequest  input  1  slave stall; readdata  input  32  valid one cycle after read accepted.

Function
REQ-020 States: IDLE, BUS, RDATA; all outputs registered.
REQ-021 IDLE + cpu_req: latch op/size/signed/addr/wdata; if misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11) pulse cpu_err next cycle, stay IDLE, no strobe; else enter BUS.
REQ-022 BUS: drive read or write, address={addr[31:2],2'b00}, byteenable, writedata; all held constant while waitrequest=1.
REQ-023 Lane k=addr[1:0]: byte -> byteenable=1<<k; half -> 0011 (k=0) or 1100 (k=2); word -> 1111.
REQ-024 writedata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-025 BUS with waitrequest=0 on a write: drop write, pulse cpu_done next cycle, return IDLE (2 edges request-to-done).
REQ-026 BUS with waitrequest=0 on a read: drop read, enter RDATA; RDATA captures readdata, extracts lane(s), extends, pulses cpu_done, returns IDLE (3 edges request-to-done).
REQ-027 Stall counter: increments each BUS cycle with waitrequest=1, clears on entry to BUS; on reaching TIMEOUT_CYCLES drop strobe, pulse cpu_err, return IDLE, cpu_rdata unchanged.
REQ-028 cpu_req while busy is ignored (no queueing); back-to-back request accepted in the cycle after cpu_done.
REQ-029 Idle outputs: read=write=0, byteenable=0, writedata=0, address=RESET_VECTOR_BASE.

Reset
REQ-030 reset_n=0 at an edge forces IDLE, read=write=0, byteenable=0, writedata=0, address=RESET_VECTOR_BASE, cpu_done=cpu_err=0, cpu_rdata=0, stall counter=0.
REQ-031 Reset mid-transfer (BUS or RDATA) aborts without cpu_done/cpu_err; in-flight readdata discarded.

Structure
REQ-032 Shared package holds size encoding enum, state enum, and RESET_VECTOR_BASE default.
REQ-033 Lane extract/extend logic in combinational sub-module load_align (inputs lane, size, signed, word; output 32-bit result).

Verification
REQ-034 Word load 0xBFC00004, waitrequest=0, readdata=0x11223344 -> one read cycle, byteenable=1111, cpu_rdata=0x11223344, cpu_done 3 edges after request.
REQ-035 Signed byte load 0xBFC00003, readdata=0x80000000 -> byteenable=1000, cpu_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Half store 0xBFC00002, wdata=0x0000ABCD, waitrequest high 3 cycles -> write/address/byteenable=1100/writedata=0xABCDABCD stable 4 cycles, then cpu_done.
REQ-037 Word load 0xBFC00001 -> cpu_err pulse next cycle, read never asserted.
REQ-038 TIMEOUT_CYCLES=4, waitrequest stuck 1 -> read dropped after 4 stall cycles, cpu_err pulse, IDLE.
REQ-039 reset_n=0 during BUS of a read -> read=0 next edge, no cpu_done, next request completes normally.
